// File: rtl/sobel_edge_core.sv
// rtl/sobel_edge_core.sv - 3-stage Sobel |Gx|+|Gy| edge stage with RGB565 output; SOBEL_EDGE_CNT_EN builds the per-frame edge counter
module sobel_edge_core #(
    parameter int DW      = 8,
    parameter int THR_DEF = 12,
    parameter int CNT_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DW-1:0]     p11,
    input  logic [DW-1:0]     p12,
    input  logic [DW-1:0]     p13,
    input  logic [DW-1:0]     p21,
    input  logic [DW-1:0]     p22,
    input  logic [DW-1:0]     p23,
    input  logic [DW-1:0]     p31,
    input  logic [DW-1:0]     p32,
    input  logic [DW-1:0]     p33,
    input  logic [DW+2:0]     thr,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic [15:0]       out_data,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic              edge_cnt_vld
);

    localparam int MW = DW + 3;
    localparam logic [MW-1:0] PMAX = {3'b000, {DW{1'b1}}};

    logic ce;
    logic accept_sof;

    logic signed [MW-1:0] w11, w12, w13, w21, w23, w31, w32, w33;
    logic signed [MW-1:0] gx_c, gy_c;
    logic [MW-1:0]        thr_c;
    logic [1:0]           mode_c;

    logic [MW-1:0] cfg_thr;
    logic [1:0]    cfg_mode;

    logic                 v1, sof1, eof1;
    logic signed [MW-1:0] gx1, gy1;
    logic [MW-1:0]        thr1;
    logic [1:0]           mode1;

    logic [MW-1:0] ax, ay, mag_c;

    logic          v2, sof2, eof2;
    logic [MW-1:0] mag2, thr2;
    logic [1:0]    mode2;

    logic        edge_c;
    logic [5:0]  s6;
    logic [15:0] grey, px_c;

    // Global stall: the whole pipe advances only when the output slot can move.
    assign ce         = out_ready | ~out_valid;
    assign in_ready   = ce;
    assign accept_sof = in_valid & in_sof;

    assign w11 = $signed({3'b000, p11});
    assign w12 = $signed({3'b000, p12});
    assign w13 = $signed({3'b000, p13});
    assign w21 = $signed({3'b000, p21});
    assign w23 = $signed({3'b000, p23});
    assign w31 = $signed({3'b000, p31});
    assign w32 = $signed({3'b000, p32});
    assign w33 = $signed({3'b000, p33});

    // Full-precision gradients and the config this beat will carry (sof beat uses its own).
    always_comb begin
        gx_c   = (w13 - w11) + ((w23 - w21) <<< 1) + (w33 - w31);
        gy_c   = (w11 - w31) + ((w12 - w32) <<< 1) + (w13 - w33);
        thr_c  = accept_sof ? thr  : cfg_thr;
        mode_c = accept_sof ? mode : cfg_mode;
    end

    // Frame config latched on an accepted sof beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_thr  <= THR_DEF[MW-1:0];
            cfg_mode <= 2'b00;
        end else if (ce && accept_sof) begin
            cfg_thr  <= thr;
            cfg_mode <= mode;
        end
    end

    // Magnitude: |Gx| + |Gy|, cannot overflow MW bits.
    always_comb begin
        ax    = gx1[MW-1] ? MW'(-gx1) : MW'(gx1);
        ay    = gy1[MW-1] ? MW'(-gy1) : MW'(gy1);
        mag_c = ax + ay;
    end

    // Threshold and RGB565 formatting; grey level keeps only the top 6 bits of the saturated magnitude.
    always_comb begin
        edge_c = (mag2 > thr2);
        s6     = 6'd0;
        if (edge_c) begin
            s6 = (mag2 > PMAX) ? 6'h3F : mag2[DW-1 -: 6];
        end
        grey = {s6[5:1], s6, s6[5:1]};
        case (mode2)
            2'b00:   px_c = edge_c ? 16'h0000 : 16'hFFFF;
            2'b01:   px_c = grey;
            2'b10:   px_c = edge_c ? 16'hFFFF : 16'h0000;
            default: px_c = ~grey;
        endcase
    end

    // Pipeline registers S1 (gradients), S2 (magnitude), S3 (output pixel).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0;
            gx1 <= '0; gy1 <= '0; thr1 <= '0; mode1 <= 2'b00;
            v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0;
            mag2 <= '0; thr2 <= '0; mode2 <= 2'b00;
            out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
            out_data  <= 16'h0000;
        end else if (ce) begin
            v1    <= in_valid;
            sof1  <= in_valid & in_sof;
            eof1  <= in_valid & in_eof;
            gx1   <= gx_c;
            gy1   <= gy_c;
            thr1  <= thr_c;
            mode1 <= mode_c;
            v2    <= v1;
            sof2  <= sof1;
            eof2  <= eof1;
            mag2  <= mag_c;
            thr2  <= thr1;
            mode2 <= mode1;
            out_valid <= v2;
            out_sof   <= sof2;
            out_eof   <= eof2;
            out_data  <= px_c;
        end
    end

`ifdef SOBEL_EDGE_CNT_EN
    logic             edge_s3;
    logic [CNT_W-1:0] run_cnt, run_nxt;

    // Edge flag travels alongside the output pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_s3 <= 1'b0;
        end else if (ce) begin
            edge_s3 <= edge_c;
        end
    end

    // Running count including the current output beat, saturating.
    always_comb begin
        run_nxt = run_cnt;
        if (edge_s3 && (run_cnt != {CNT_W{1'b1}})) begin
            run_nxt = run_cnt + 1'b1;
        end
    end

    // Count runs eof to eof; publish and clear on the eof handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt      <= '0;
            edge_cnt     <= '0;
            edge_cnt_vld <= 1'b0;
        end else begin
            edge_cnt_vld <= 1'b0;
            if (out_valid && out_ready) begin
                if (out_eof) begin
                    edge_cnt     <= run_nxt;
                    edge_cnt_vld <= 1'b1;
                    run_cnt      <= '0;
                end else begin
                    run_cnt <= run_nxt;
                end
            end
        end
    end
`else
    assign edge_cnt     = '0;
    assign edge_cnt_vld = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_edge_core.sv
// tb/tb_sobel_edge_core.sv - scoreboard bench for sobel_edge_core
module tb_sobel_edge_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0]  p11 = '0, p12 = '0, p13 = '0, p21 = '0, p22 = '0, p23 = '0, p31 = '0, p32 = '0, p33 = '0;
    logic [10:0] thr = '0;
    logic [1:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof, out_eof;
    logic [15:0] out_data;
    logic [19:0] edge_cnt;
    logic        edge_cnt_vld;

    sobel_edge_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_eof(in_eof),
        .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33),
        .thr(thr), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .out_data(out_data),
        .edge_cnt(edge_cnt), .edge_cnt_vld(edge_cnt_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eof;
        logic        edg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_thr = 12;
    int   m_mode = 0;
    bit   rdy_mode = 0;
    int   pc = 0;

    localparam logic [71:0] FLAT = {9{8'd100}};
    localparam logic [71:0] STEP = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
    localparam logic [71:0] EXT  = {8'd255, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_px(input logic [71:0] w, input int t, input int m);
        int p[9];
        int gx, gy, mag, s, grey;
        bit e;
        logic [15:0] px;
        for (int k = 0; k < 9; k++) p[k] = int'(w[71 - 8*k -: 8]);
        gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        gy = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e = (mag > t);
        s = e ? (mag > 255 ? 255 : mag) : 0;
        grey = ((s >> 3) << 11) | ((s >> 2) << 5) | (s >> 3);
        case (m)
            0:       px = e ? 16'h0000 : 16'hFFFF;
            1:       px = grey[15:0];
            2:       px = e ? 16'hFFFF : 16'h0000;
            default: px = ~grey[15:0];
        endcase
        return {e, px};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            out_ready = (pc % 3 == 0);
            pc++;
        end else begin
            out_ready = 1'b1;
            pc = 0;
        end
    end

    task automatic send(input logic [71:0] w, input bit sof, input bit eof, input int t, input int m, input bit lat);
        exp_t e;
        logic [16:0] r;
        bit done = 0;
        in_valid = 1'b1;
        in_sof = sof;
        in_eof = eof;
        {p11, p12, p13, p21, p22, p23, p31, p32, p33} = w;
        thr  = sof ? t[10:0] : 11'h7FF;
        mode = sof ? m[1:0] : 2'(~m[1:0]);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sof) begin
                    m_thr = t;
                    m_mode = m;
                end
                r = ref_px(w, m_thr, m_mode);
                e.data = r[15:0];
                e.edg = r[16];
                e.sof = sof;
                e.eof = eof;
                e.acc = cyc;
                e.lat = lat;
                sbq.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_thr = 12;
        m_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int          run = 0;
    int          exp_cnt = 0;
    bit          exp_vld_next = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;

    // Output monitor: scoreboard pop, hold checks during stalls, edge counter model.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            run = 0;
            exp_vld_next = 0;
            prev_stall = 0;
        end else begin
            if (exp_vld_next) begin
                exp_vld_next = 0;
`ifdef SOBEL_EDGE_CNT_EN
                check("cnt_vld", edge_cnt_vld, 1);
                check("cnt_val", edge_cnt, exp_cnt);
`else
                check("cnt_vld_tied", edge_cnt_vld, 0);
                check("cnt_val_tied", edge_cnt, 0);
`endif
            end else if (edge_cnt_vld) begin
                check("cnt_vld_spurious", edge_cnt_vld, 0);
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("extra_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("data", out_data, e.data);
                    check("sof", out_sof, e.sof);
                    check("eof", out_eof, e.eof);
                    if (e.lat) check("latency", cyc - e.acc, 3);
                    if (e.edg && run < 20'hFFFFF) run++;
                    if (e.eof) begin
                        exp_cnt = run;
                        exp_vld_next = 1;
                        run = 0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        logic [95:0] rnd;
        int bt, bm;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_in_ready", in_ready, 1);
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_edge_vld", edge_cnt_vld, 0);
        @(posedge clk);
        #1;

        // Flat window, reset config, latency
        send(FLAT, 0, 0, 0, 0, 1);
        drain();
        // Step in mode 00 then 01
        send(STEP, 1, 0, 12, 0, 1);
        send(STEP, 1, 0, 12, 1, 0);
        // Extreme sign case in modes 01, 11, 10
        send(EXT, 1, 0, 12, 1, 0);
        send(EXT, 1, 0, 12, 3, 0);
        send(EXT, 1, 1, 12, 2, 0);
        drain();

        // Config change with frame-1 beats in flight
        send(STEP, 1, 0, 12, 0, 0);
        send(STEP, 0, 0, 0, 0, 0);
        send(STEP, 0, 1, 0, 0, 0);
        send(STEP, 1, 0, 2000, 0, 0);
        send(STEP, 0, 0, 0, 0, 0);
        send(FLAT, 0, 1, 0, 0, 0);
        drain();

        // Backpressure: random frame of 10 beats with out_ready 1,0,0 pattern
        rdy_mode = 1;
        bt = $urandom_range(0, 1500);
        bm = $urandom_range(0, 3);
        for (int i = 0; i < 10; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            send(rnd[71:0], i == 0, i == 9, bt, bm, 0);
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 4-pixel frame with 3 edge pixels
        send(STEP, 1, 0, 12, 0, 0);
        send(FLAT, 0, 0, 0, 0, 0);
        send(STEP, 0, 0, 0, 0, 0);
        send(EXT, 0, 1, 0, 0, 0);
        drain();
`ifdef SOBEL_EDGE_CNT_EN
        check("frame_cnt3", edge_cnt, 3);
`else
        check("frame_cnt_tied", edge_cnt, 0);
`endif

        // Reset mid-frame, then a one-pixel sof+eof edge frame
        send(STEP, 1, 0, 12, 0, 0);
        send(STEP, 0, 0, 0, 0, 0);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        send(STEP, 1, 1, 12, 0, 0);
        drain();
`ifdef SOBEL_EDGE_CNT_EN
        check("one_px_cnt", edge_cnt, 1);
`else
        check("one_px_cnt_tied", edge_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        check("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_edge_core.md
# sobel_edge_core

Parametrised Sobel edge stage for the camera pipeline. It takes a 3×3 grey-level window per pixel and computes the full-precision gradient magnitude |Gx|+|Gy|. It then emits either a thresholded binary pixel or a noise-floored magnitude pixel in RGB565 towards the SDRAM write path. Compared with the previous detector it adds generic pixel width, a runtime threshold and mode latched per frame, ready/valid backpressure, frame sideband, and an optional per-frame edge counter.

## Interface
- DW, 8: pixel width of window taps (DW ≥ 6)
- MW, DW+3: magnitude/threshold width (fixed by DW; not to be overridden)
- THR_DEF, 12: threshold value after reset
- CNT_W, 20: edge counter width

- clk  in  1  pipeline clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  window beat valid
- in_ready  out  1  core can accept a beat this cycle
- in_sof / in_eof  in  1 / 1  first / last pixel of frame, qualified by in_valid
- p11..p33  in  DW each  window taps, row-major, unsigned
- thr  in  MW  runtime threshold, sampled on accepted in_sof beat
- mode  in  2  output mode, sampled with thr
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sof / out_eof  out  1 / 1  sideband aligned with out_data
- out_data  out  16  RGB565 pixel
- edge_cnt  out  CNT_W  edge pixels in last completed frame
- edge_cnt_vld  out  1  one-cycle strobe when edge_cnt updates

## Operation
- Stage S1 computes Gx and Gy as signed MW bits with no truncation:
  - Gx = (p13−p11) + 2(p23−p21) + (p33−p31)
  - Gy = (p11−p31) + 2(p12−p32) + (p13−p33)
  - Range ±4·(2^DW−1).
- Stage S2 computes mag = |Gx|+|Gy| as unsigned MW bits; maximum 8·(2^DW−1) fits.
- Stage S3 sets edge = (mag > cfg_thr) and formats the pixel:
  - mode 00: edge → 16'h0000 (black), else 16'hFFFF.
  - mode 01: s = min(mag, 2^DW−1), forced to 0 when !edge; out = {s[DW−1-:5], s[DW−1-:6], s[DW−1-:5]}.
  - mode 10: inverse of 00.
  - mode 11: bitwise inverse of 01.
- Config (thr, mode) is captured on each accepted beat with in_sof=1.
  - That beat and all later beats use the new config.
  - Config values travel down the pipe with the data, so beats already in flight keep their old config.
  - Without an in_sof beat, config holds at its reset values: THR_DEF and mode 00.
- Flow control is a global-stall pipeline:
  - ce = out_ready | ~out_valid; in_ready = ce.
  - When ce=0, every stage register, valid bit and sideband bit holds.
  - Bubbles are not compressed.
- A beat is accepted when in_valid & in_ready; sof/eof travel with it.

## Timing
- Latency is 3 clocks from accepted input to out_valid while out_ready is held at 1. Throughput is 1 beat/clock.
- Reset values:
  - out_valid=0, out_sof=0, out_eof=0, out_data=16'h0000.
  - Internal valids 0; cfg_thr=THR_DEF, cfg_mode=00.
  - edge_cnt=0, edge_cnt_vld=0, running count 0.
- in_ready is 1 out of reset.
- Reset asserted mid-frame drops every in-flight beat on the next edge. No partial edge_cnt_vld is produced.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Edge counter:
  - It increments on each output handshake with edge=1, in every mode, and saturates at 2^CNT_W−1.
  - On an output handshake with out_eof=1, edge_cnt takes the running count including that beat, edge_cnt_vld pulses for 1 clock, and the running count clears.
  - A beat with both sof and eof set counts as a one-pixel frame.
  - If an sof beat arrives before any eof, the count is not cleared; counting runs from eof to eof.

## Configuration
- SOBEL_EDGE_CNT_EN defined: the edge counter logic described above is built.
- Not defined: no counter registers; edge_cnt is tied to 0 and edge_cnt_vld to 0. Datapath behaviour and latency are identical.

## Test plan
- Flat window, all taps 100, thr=12, mode 00 → out_data=16'hFFFF 3 clocks after the beat; mag=0.
- Vertical step (left column 0, right column 255, DW=8), mode 00 → Gx=1020, mag=1020, out_data=16'h0000. Same beat in mode 01 → s=255, out_data=16'hFFFF.
- Extreme sign case (p11=p21=p31=p12=255, others 0) → Gx=−1020, Gy=+510, mag=1530 with no overflow. Mode 01 saturates to 16'hFFFF; mode 11 gives 16'h0000.
- Config change:
  - Frame 1 uses thr=12; frame 2 sof beat carries thr=2000.
  - Frame-1 beats still in flight use thr 12.
  - From the sof beat of frame 2 on, the step window outputs 16'hFFFF.
- Backpressure: stream 10 beats with out_ready toggling 1,0,0,1… → no loss or duplication, order kept, data held during stalls, in_ready=0 whenever out_valid & ~out_ready.
- With SOBEL_EDGE_CNT_EN: 4-pixel frame with 3 edge pixels, eof on the last beat → edge_cnt=3 and a single edge_cnt_vld pulse on the eof handshake. Reset mid-frame followed by a 1-pixel sof+eof edge frame → edge_cnt=1.
